sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM controller internal interface (command/address, write-data mask, read-return) between NUM_PORTS wishbone port instances.
- Grants are round-robin. A grant is held for one complete controller burst, delimited by done_i.
- Read-return data is steered only to the port that owns the grant.
- Sits in the sdram_clk domain, between the port instances and the controller core.

---
 rtl/sdram_port_arbiter_pkg.sv | 37 +++
 rtl/sdram_rr_picker.sv | 33 +++
 rtl/sdram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter slice.
//   arb_state_t    : arbiter FSM encoding (IDLE, OWNED)
//   first_set_from : index of first set request bit at/after a rotating pointer
//   slice_lo       : low bit of port k's slice in a packed per-port bus
package sdram_port_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_PORTS = 8;

  // Scans n ports starting at ptr, wrapping modulo n; returns 0 when req is empty.
  function automatic logic [2:0] first_set_from(input logic [MAX_PORTS-1:0] req,
                                                input int unsigned n,
                                                input int unsigned ptr);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      int unsigned j;
      j = (ptr + i) % n;
      if (i < n && !found && req[j]) begin
        idx   = 3'(j);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per port
//   ptr    : highest-priority port index
//   choice : one-hot selected port (0 when no request)
//   index  : binary index of the selected port
//   any    : at least one request present
module sdram_rr_picker
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  choice,
  output logic [PW-1:0] index,
  output logic          any
);

  logic [MAX_PORTS-1:0] req_ext;
  logic [2:0]           idx3;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    idx3           = first_set_from(req_ext, N, 32'(ptr));
    index          = PW'(idx3);
    any            = |req;
    choice         = '0;
    if (any) choice[index] = 1'b1;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller interface among NUM_PORTS ports.
// A grant is held for one controller burst (ended by done_i) or until the idle
// counter expires (timeout_o pulse). Forwarding is a combinational mux on the
// registered owner; nothing is forwarded while IDLE.
//   p_ca_* / p_dm_* : packed per-port command and write-data inputs
//   p_ca_ready_o    : controller ready routed to the owner only
//   p_r_valid_o     : read-return valid routed to the owner only
//   ca_* / dm_*     : controller-side command and write-data outputs
//   ca_ready_i, r_valid_i, done_i : controller handshakes
//   grant_o         : one-hot owner, timeout_o : forced-release pulse
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst_n,
  input  logic [NUM_PORTS*AW-1:0]   p_ca_adr_i,
  input  logic [NUM_PORTS-1:0]      p_ca_we_i,
  input  logic [NUM_PORTS-1:0]      p_ca_valid_i,
  output logic [NUM_PORTS-1:0]      p_ca_ready_o,
  input  logic [NUM_PORTS*DW-1:0]   p_dm_dat_i,
  input  logic [NUM_PORTS*DW/8-1:0] p_dm_sel_i,
  input  logic [NUM_PORTS-1:0]      p_dm_valid_i,
  output logic [NUM_PORTS-1:0]      p_r_valid_o,
  output logic [AW-1:0]             ca_adr_o,
  output logic                      ca_we_o,
  output logic                      ca_valid_o,
  input  logic                      ca_ready_i,
  output logic [DW-1:0]             dm_dat_o,
  output logic [DW/8-1:0]           dm_sel_o,
  output logic                      dm_valid_o,
  input  logic                      r_valid_i,
  input  logic                      done_i,
  output logic [NUM_PORTS-1:0]      grant_o,
  output logic                      timeout_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  arb_state_t           state, next_state;
  logic [NUM_PORTS-1:0] grant;
  logic [PW-1:0]        owner, rr_ptr, rr_next;
  logic [CW-1:0]        idle_cnt;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 activity, timeout_hit;
  int unsigned          adr_lo, dat_lo, sel_lo;

  sdram_rr_picker #(.N(NUM_PORTS), .PW(PW)) u_picker (
    .req    (p_ca_valid_i),
    .ptr    (rr_ptr),
    .choice (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  assign grant_o = grant;
  assign rr_next = (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state   = state;
    timeout_hit  = 1'b0;
    activity     = 1'b0;
    adr_lo       = slice_lo(32'(owner), AW);
    dat_lo       = slice_lo(32'(owner), DW);
    sel_lo       = slice_lo(32'(owner), SW);
    ca_adr_o     = '0;
    ca_we_o      = 1'b0;
    ca_valid_o   = 1'b0;
    dm_dat_o     = '0;
    dm_sel_o     = '0;
    dm_valid_o   = 1'b0;
    p_ca_ready_o = '0;
    p_r_valid_o  = '0;
    case (state)
      IDLE: if (pick_any) next_state = OWNED;
      OWNED: begin
        ca_adr_o            = p_ca_adr_i[adr_lo +: AW];
        ca_we_o             = p_ca_we_i[owner];
        ca_valid_o          = p_ca_valid_i[owner];
        dm_dat_o            = p_dm_dat_i[dat_lo +: DW];
        dm_sel_o            = p_dm_sel_i[sel_lo +: SW];
        dm_valid_o          = p_dm_valid_i[owner];
        p_ca_ready_o[owner] = ca_ready_i;
        p_r_valid_o[owner]  = r_valid_i;
        activity            = (p_ca_valid_i[owner] & ca_ready_i) | r_valid_i;
        // done_i wins over an expiring counter, so no timeout pulse then.
        if (done_i) begin
          next_state = IDLE;
        end else if (TO_EN && idle_cnt == LIMIT && !activity) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant    <= pick_onehot;
            owner    <= pick_idx;
            idle_cnt <= '0;
          end
        end
        OWNED: begin
          if (next_state == IDLE) begin
            grant    <= '0;
            rr_ptr   <= rr_next;
            idle_cnt <= '0;
          end else if (activity) begin
            idle_cnt <= '0;
          end else if (TO_EN && idle_cnt != LIMIT) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int unsigned NP = 2, AW = 32, DW = 16, SW = DW / 8, TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*AW-1:0]  p_ca_adr_i = '0;
  logic [NP-1:0]     p_ca_we_i = '0, p_ca_valid_i = '0, p_dm_valid_i = '0;
  logic [NP-1:0]     p_ca_ready_o, p_r_valid_o, grant_o;
  logic [NP*DW-1:0]  p_dm_dat_i = '0;
  logic [NP*SW-1:0]  p_dm_sel_i = '0;
  logic [AW-1:0]     ca_adr_o;
  logic              ca_we_o, ca_valid_o, dm_valid_o, timeout_o;
  logic              ca_ready_i = 1'b0, r_valid_i = 1'b0, done_i = 1'b0;
  logic [DW-1:0]     dm_dat_o;
  logic [SW-1:0]     dm_sel_o;

  int unsigned pass_cnt = 0, total_cnt = 0;
  logic [NP-1:0] grant_q[$];
  logic [NP-1:0] rv_q[$];
  logic [NP-1:0] exp_g;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .sdram_clk(clk), .sdram_rst_n(rst_n),
    .p_ca_adr_i(p_ca_adr_i), .p_ca_we_i(p_ca_we_i), .p_ca_valid_i(p_ca_valid_i),
    .p_ca_ready_o(p_ca_ready_o), .p_dm_dat_i(p_dm_dat_i), .p_dm_sel_i(p_dm_sel_i),
    .p_dm_valid_i(p_dm_valid_i), .p_r_valid_o(p_r_valid_o),
    .ca_adr_o(ca_adr_o), .ca_we_o(ca_we_o), .ca_valid_o(ca_valid_o), .ca_ready_i(ca_ready_i),
    .dm_dat_o(dm_dat_o), .dm_sel_o(dm_sel_o), .dm_valid_o(dm_valid_o),
    .r_valid_i(r_valid_i), .done_i(done_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic release_burst();
    @(posedge clk); #1 done_i = 1'b1; p_ca_valid_i = '0; p_dm_valid_i = '0; ca_ready_i = 1'b0;
    @(posedge clk); #1 done_i = 1'b0;
  endtask

  task automatic test_reset();
    p_ca_valid_i = '1; ca_ready_i = 1'b1; r_valid_i = 1'b1; p_dm_valid_i = '1;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant_o); else pass_cnt++;
    total_cnt++; if ({ca_valid_o, dm_valid_o, timeout_o} !== 3'b000) $display("FAIL reset_valids: got %b want 000", {ca_valid_o, dm_valid_o, timeout_o}); else pass_cnt++;
    total_cnt++; if ({p_ca_ready_o, p_r_valid_o} !== 4'b0000) $display("FAIL reset_port_out: got %b want 0000", {p_ca_ready_o, p_r_valid_o}); else pass_cnt++;
    total_cnt++; if ({ca_adr_o, dm_dat_o, dm_sel_o, ca_we_o} !== '0) $display("FAIL reset_data: got %h want 0", {ca_adr_o, dm_dat_o, dm_sel_o, ca_we_o}); else pass_cnt++;
    p_ca_valid_i = '0; ca_ready_i = 1'b0; r_valid_i = 1'b0; p_dm_valid_i = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    p_ca_valid_i[1] = 1'b1; p_ca_adr_i[AW +: AW] = 32'h100; p_ca_we_i[1] = 1'b1; ca_ready_i = 1'b1;
    grant_q.push_back(2'b10);
    @(negedge clk);
    total_cnt++; if ({grant_o, ca_valid_o} !== 3'b000) $display("FAIL single_decision: got %b want 000", {grant_o, ca_valid_o}); else pass_cnt++;
    @(negedge clk);
    exp_g = grant_q.pop_front();
    total_cnt++; if (grant_o !== exp_g) $display("FAIL single_grant: got %b want %b", grant_o, exp_g); else pass_cnt++;
    total_cnt++; if ({ca_adr_o, ca_we_o, ca_valid_o} !== {32'h100, 2'b11}) $display("FAIL single_cmd: got %h/%b/%b want 100/1/1", ca_adr_o, ca_we_o, ca_valid_o); else pass_cnt++;
    total_cnt++; if (p_ca_ready_o !== 2'b10) $display("FAIL single_ready_hi: got %b want 10", p_ca_ready_o); else pass_cnt++;
    @(posedge clk); #1 ca_ready_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (p_ca_ready_o !== 2'b00) $display("FAIL single_ready_lo: got %b want 00", p_ca_ready_o); else pass_cnt++;
    release_burst();
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL single_release: got %b want 00", grant_o); else pass_cnt++;
  endtask

  task automatic test_contention();
    @(posedge clk); #1 p_ca_valid_i = 2'b11; ca_ready_i = 1'b1;
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    for (int i = 0; i < 4; i++) begin
      int unsigned idle = 0;
      @(negedge clk);
      while (grant_o == '0 && idle < 8) begin idle++; @(negedge clk); end
      exp_g = grant_q.pop_front();
      total_cnt++; if (grant_o !== exp_g) $display("FAIL contention_grant%0d: got %b want %b", i, grant_o, exp_g); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (idle !== 1) $display("FAIL contention_gap%0d: got %0d want 1", i, idle); else pass_cnt++;
      end
      @(posedge clk); #1 done_i = 1'b1; if (i == 3) p_ca_valid_i = '0;
      @(posedge clk); #1 done_i = 1'b0;
    end
    ca_ready_i = 1'b0;
  endtask

  task automatic test_read_steering();
    logic [5:0] pat = 6'b101101;
    int unsigned n = 0, ones = 0;
    @(posedge clk); #1 p_ca_valid_i = 2'b01;
    grant_q.push_back(2'b01);
    @(negedge clk);
    while (grant_o == '0 && n < 8) begin n++; @(negedge clk); end
    exp_g = grant_q.pop_front();
    total_cnt++; if (grant_o !== exp_g) $display("FAIL read_grant: got %b want %b", grant_o, exp_g); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 r_valid_i = pat[i];
      rv_q.push_back(pat[i] ? 2'b01 : 2'b00);
      @(negedge clk);
      exp_g = rv_q.pop_front();
      if (p_r_valid_o[0]) ones++;
      total_cnt++; if (p_r_valid_o !== exp_g) $display("FAIL read_steer%0d: got %b want %b", i, p_r_valid_o, exp_g); else pass_cnt++;
    end
    total_cnt++; if (ones !== 4) $display("FAIL read_count: got %0d want 4", ones); else pass_cnt++;
    @(posedge clk); #1 r_valid_i = 1'b0;
    release_burst();
    r_valid_i = 1'b1;
    @(negedge clk);
    total_cnt++; if ({grant_o, p_r_valid_o} !== 4'b0000) $display("FAIL read_idle_drop: got %b want 0000", {grant_o, p_r_valid_o}); else pass_cnt++;
    @(posedge clk); #1 r_valid_i = 1'b0;
  endtask

  task automatic test_timeout();
    int unsigned n = 0;
    @(posedge clk); #1 p_ca_valid_i = 2'b11;
    grant_q.push_back(2'b10);
    @(negedge clk);
    while (grant_o == '0 && n < 8) begin n++; @(negedge clk); end
    exp_g = grant_q.pop_front();
    total_cnt++; if (grant_o !== exp_g) $display("FAIL timeout_grant: got %b want %b", grant_o, exp_g); else pass_cnt++;
    n = 0;
    while (!timeout_o && n < 20) begin @(negedge clk); n++; end
    total_cnt++; if (n !== TO) $display("FAIL timeout_latency: got %0d want %0d", n, TO); else pass_cnt++;
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL timeout_idle: got %b want 00", grant_o); else pass_cnt++;
    grant_q.push_back(2'b01);
    @(negedge clk);
    exp_g = grant_q.pop_front();
    total_cnt++; if ({timeout_o, grant_o} !== {1'b0, exp_g}) $display("FAIL timeout_next: got %b want %b", {timeout_o, grant_o}, {1'b0, exp_g}); else pass_cnt++;
    release_burst();
  endtask

  task automatic test_done_at_limit();
    int unsigned n = 0;
    @(posedge clk); #1 p_ca_valid_i = 2'b10;
    grant_q.push_back(2'b10);
    @(negedge clk);
    while (grant_o == '0 && n < 8) begin n++; @(negedge clk); end
    exp_g = grant_q.pop_front();
    total_cnt++; if (grant_o !== exp_g) $display("FAIL limit_grant: got %b want %b", grant_o, exp_g); else pass_cnt++;
    repeat (TO - 1) @(posedge clk);
    #1 done_i = 1'b1; p_ca_valid_i = '0;
    @(posedge clk); #1 done_i = 1'b0;
    @(negedge clk);
    total_cnt++; if ({timeout_o, grant_o} !== 3'b000) $display("FAIL limit_release: got %b want 000", {timeout_o, grant_o}); else pass_cnt++;
    @(posedge clk); #1 p_ca_valid_i = 2'b11;
    grant_q.push_back(2'b01);
    n = 0;
    @(negedge clk);
    while (grant_o == '0 && n < 8) begin n++; @(negedge clk); end
    exp_g = grant_q.pop_front();
    total_cnt++; if ({timeout_o, grant_o} !== {1'b0, exp_g}) $display("FAIL limit_rr_once: got %b want %b", {timeout_o, grant_o}, {1'b0, exp_g}); else pass_cnt++;
    release_burst();
  endtask

  task automatic test_async_reset();
    int unsigned n = 0;
    @(posedge clk); #1;
    p_ca_valid_i = 2'b01; p_dm_valid_i = 2'b01; p_dm_dat_i[0 +: DW] = 16'hBEEF; p_dm_sel_i[0 +: SW] = 2'b11;
    grant_q.push_back(2'b01);
    @(negedge clk);
    while (grant_o == '0 && n < 8) begin n++; @(negedge clk); end
    exp_g = grant_q.pop_front();
    total_cnt++; if (grant_o !== exp_g) $display("FAIL areset_grant: got %b want %b", grant_o, exp_g); else pass_cnt++;
    total_cnt++; if ({dm_valid_o, dm_dat_o, dm_sel_o} !== {1'b1, 16'hBEEF, 2'b11}) $display("FAIL areset_write: got %b/%h/%b want 1/beef/11", dm_valid_o, dm_dat_o, dm_sel_o); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({dm_valid_o, ca_valid_o, grant_o} !== 4'b0000) $display("FAIL areset_drop: got %b want 0000", {dm_valid_o, ca_valid_o, grant_o}); else pass_cnt++;
    @(posedge clk); #1 p_ca_valid_i = 2'b11; p_dm_valid_i = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    grant_q.push_back(2'b01);
    n = 0;
    @(negedge clk);
    while (grant_o == '0 && n < 8) begin n++; @(negedge clk); end
    exp_g = grant_q.pop_front();
    total_cnt++; if (grant_o !== exp_g) $display("FAIL areset_first_grant: got %b want %b", grant_o, exp_g); else pass_cnt++;
    release_burst();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_read_steering();
    test_timeout();
    test_done_at_limit();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
